// File: rtl/peripheral_ram_tl_bridge_pkg.sv
// Shared TL-UL constants, FSM state type and mask-legality helper for the RAM bridge.
package peripheral_tl_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    localparam logic [2:0] ACK         = 3'd0;
    localparam logic [2:0] ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    // PutFullData must carry exactly the lanes covered by size at the given byte offset.
    function automatic logic full_mask_ok(input logic [1:0] size,
                                          input logic [1:0] offset,
                                          input logic [3:0] mask);
        logic [3:0] expected;
        case (size)
            2'd0:    expected = 4'b0001 << offset;
            2'd1:    expected = 4'b0011 << offset;
            default: expected = 4'b1111;
        endcase
        return mask == expected;
    endfunction

endpackage

// File: rtl/peripheral_ram_tl_bridge_if.sv
// TL-UL A and D channel bundle between the crossbar (master) and the RAM bridge (slave).
interface peripheral_ram_tl_bridge_if #(
    parameter int TL_AW = 32,
    parameter int TL_SW = 4,
    parameter int DW    = 32
);
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [TL_SW-1:0] a_source;
    logic [TL_AW-1:0] a_address;
    logic [3:0]       a_mask;
    logic [DW-1:0]    a_data;

    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_opcode;
    logic [1:0]       d_size;
    logic [TL_SW-1:0] d_source;
    logic [DW-1:0]    d_data;
    logic             d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );
endinterface

// File: rtl/peripheral_ram_tl_bridge.sv
// TL-UL slave front end for a byte-enabled RAM macro with one transaction in flight.
module peripheral_ram_tl_bridge
    import peripheral_tl_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32,
    parameter int TL_AW = 32,
    parameter int TL_SW = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    peripheral_ram_tl_bridge_if.slave tl,
    output logic [3:0]               ram_we,
    output logic [DW-1:0]            ram_din,
    output logic [AW-1:0]            ram_waddr,
    output logic [AW-1:0]            ram_raddr,
    input  logic [DW-1:0]            ram_dout
);

    state_t           state;
    logic [DW-1:0]    d_data_r;
    logic             rd_fresh;
    logic             req_err;
    logic             is_get;
    logic [AW-1:0]    word_addr;
    logic             unused_param;

    assign unused_param = ^tl.a_param;
    assign tl.a_ready   = (state == IDLE) && !rst;
    assign word_addr    = tl.a_address[AW+1:2];

    // Request legality decode on the live A channel.
    always_comb begin
        req_err = 1'b0;
        is_get  = (tl.a_opcode == GET);
        if (|tl.a_address[TL_AW-1:AW+2]) begin
            req_err = 1'b1;
        end else begin
            req_err = 1'b0;
        end
        if (tl.a_size > 2'd2) begin
            req_err = 1'b1;
        end else if ((tl.a_size == 2'd1 && tl.a_address[0]) ||
                     (tl.a_size == 2'd2 && |tl.a_address[1:0])) begin
            req_err = 1'b1;
        end else begin
            req_err = req_err;
        end
        if (tl.a_opcode != PUT_FULL && tl.a_opcode != PUT_PARTIAL && !is_get) begin
            req_err = 1'b1;
        end else if (tl.a_opcode == PUT_FULL &&
                     !full_mask_ok(tl.a_size, tl.a_address[1:0], tl.a_mask)) begin
            req_err = 1'b1;
        end else if (tl.a_mask == 4'd0) begin
            req_err = 1'b1;
        end else begin
            req_err = req_err;
        end
    end

    // The RAM's registered output lands during the first response cycle, so d_data
    // passes it straight through then and holds the latched copy afterwards.
    assign tl.d_data = rd_fresh ? ram_dout : d_data_r;

    // Bridge FSM with registered D-channel and RAM-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tl.d_valid  <= 1'b0;
            tl.d_opcode <= 3'd0;
            tl.d_size   <= 2'd0;
            tl.d_source <= '0;
            tl.d_error  <= 1'b0;
            d_data_r    <= '0;
            rd_fresh    <= 1'b0;
            ram_we      <= 4'd0;
            ram_din     <= '0;
            ram_waddr   <= '0;
            ram_raddr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_we <= 4'd0;
                    if (tl.a_valid) begin
                        tl.d_size   <= tl.a_size;
                        tl.d_source <= tl.a_source;
                        if (req_err) begin
                            tl.d_valid  <= 1'b1;
                            tl.d_error  <= 1'b1;
                            tl.d_opcode <= is_get ? ACK_DATA : ACK;
                            d_data_r    <= '0;
                            state       <= RESP;
                        end else if (is_get) begin
                            tl.d_error <= 1'b0;
                            ram_raddr  <= word_addr;
                            state      <= RD_WAIT;
                        end else begin
                            tl.d_valid  <= 1'b1;
                            tl.d_error  <= 1'b0;
                            tl.d_opcode <= ACK;
                            d_data_r    <= '0;
                            ram_we      <= tl.a_mask;
                            ram_waddr   <= word_addr;
                            ram_din     <= tl.a_data;
                            state       <= RESP;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    tl.d_valid  <= 1'b1;
                    tl.d_opcode <= ACK_DATA;
                    rd_fresh    <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    ram_we   <= 4'd0;
                    rd_fresh <= 1'b0;
                    if (rd_fresh) begin
                        d_data_r <= ram_dout;
                    end else begin
                        d_data_r <= d_data_r;
                    end
                    if (tl.d_ready) begin
                        tl.d_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_ram_tl_bridge.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic vs a reference model.
module tb_peripheral_ram_tl_bridge;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ram_we;
    logic [31:0] ram_din;
    logic [7:0]  ram_waddr;
    logic [7:0]  ram_raddr;
    logic [31:0] ram_dout;
    logic        clear_mem = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    peripheral_ram_tl_bridge_if #(.TL_AW(32), .TL_SW(4), .DW(32)) bus ();

    peripheral_ram_tl_bridge #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .tl        (bus),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM macro model: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
            ram_dout <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
            ram_dout <= mem[ram_raddr];
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [3:0]  src;
        logic [2:0]  e_op;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit ref_error(input logic [2:0] op, input logic [1:0] sz,
                                     input logic [31:0] addr, input logic [3:0] mask);
        int bytes;
        if (addr >= DEPTH * 4) return 1'b1;
        if (sz > 2) return 1'b1;
        bytes = 1 << sz;
        if (addr % bytes != 0) return 1'b1;
        if (op != 3'd0 && op != 3'd1 && op != 3'd4) return 1'b1;
        if (mask == 4'd0) return 1'b1;
        if (op == 3'd0 && int'(mask) != ((((1 << bytes) - 1) << (addr % 4)) & 15)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_apply(input logic [2:0] op, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] data);
        int w;
        w = addr / 4;
        if (op != 3'd4)
            for (int b = 0; b < 4; b++)
                if (mask[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic txn(input vec_t v, input int hold, input string name);
        int          lat;
        int          we_cnt;
        logic [3:0]  we_seen;
        logic [7:0]  wa_seen;
        logic [31:0] din_seen;
        bit          got;
        bit          stable;
        bit          is_wr;
        @(negedge clk);
        bus.a_valid   = 1'b1;
        bus.a_opcode  = v.op;
        bus.a_size    = v.sz;
        bus.a_address = v.addr;
        bus.a_mask    = v.mask;
        bus.a_data    = v.data;
        bus.a_source  = v.src;
        bus.d_ready   = (hold == 0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.a_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_accept"}, {31'd0, got}, 32'd1);
        @(posedge clk);
        #1 bus.a_valid = 1'b0;
        lat = 0; we_cnt = 0; we_seen = 4'd0; wa_seen = 8'd0; din_seen = 32'd0; got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (ram_we != 4'd0) begin
                we_cnt++; we_seen = ram_we; wa_seen = ram_waddr; din_seen = ram_din;
            end
            if (bus.d_valid) begin
                got = 1'b1; lat = i;
            end
        end
        is_wr = !v.e_err && v.op != 3'd4;
        chk({name, "_latency"}, lat, (v.e_err || v.op != 3'd4) ? 32'd1 : 32'd2);
        chk({name, "_d_opcode"}, {29'd0, bus.d_opcode}, {29'd0, v.e_op});
        chk({name, "_d_error"}, {31'd0, bus.d_error}, {31'd0, v.e_err});
        chk({name, "_d_data"}, bus.d_data, v.e_data);
        chk({name, "_d_size"}, {30'd0, bus.d_size}, {30'd0, v.sz});
        chk({name, "_d_source"}, {28'd0, bus.d_source}, {28'd0, v.src});
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (ram_we != 4'd0) we_cnt++;
            if (!bus.d_valid || bus.d_data !== v.e_data || bus.a_ready ||
                bus.d_source !== v.src || bus.d_error !== v.e_err) stable = 1'b0;
        end
        if (hold > 0) chk({name, "_hold_stable"}, {31'd0, stable}, 32'd1);
        bus.d_ready = 1'b1;
        @(negedge clk);
        if (ram_we != 4'd0) we_cnt++;
        chk({name, "_d_valid_drop"}, {31'd0, bus.d_valid}, 32'd0);
        chk({name, "_we_pulses"}, we_cnt, is_wr ? 32'd1 : 32'd0);
        if (is_wr) begin
            chk({name, "_we_mask"}, {28'd0, we_seen}, {28'd0, v.mask});
            chk({name, "_waddr"}, {24'd0, wa_seen}, v.addr / 4);
            chk({name, "_din"}, din_seen, v.data);
        end
        if (is_wr) ref_apply(v.op, v.addr, v.mask, v.data);
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        bus.a_valid = 1'b0; bus.a_opcode = 3'd0; bus.a_param = 3'd0; bus.a_size = 2'd0;
        bus.a_source = 4'd0; bus.a_address = 32'd0; bus.a_mask = 4'd0; bus.a_data = 32'd0;
        bus.d_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

        vecs.push_back('{3'd0, 2'd2, 32'h10,  4'hF, 32'hDEADBEEF, 4'h1, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        4'h2, 3'd1, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{3'd1, 2'd2, 32'h10,  4'h5, 32'h11223344, 4'h3, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        4'h4, 3'd1, 1'b0, 32'hDE22BE44});
        vecs.push_back('{3'd4, 2'd2, 32'h400, 4'hF, 32'h0,        4'h5, 3'd1, 1'b1, 32'h0});
        vecs.push_back('{3'd2, 2'd2, 32'h10,  4'hF, 32'h99999999, 4'h6, 3'd0, 1'b1, 32'h0});
        vecs.push_back('{3'd4, 2'd2, 32'h10,  4'hF, 32'h0,        4'h8, 3'd1, 1'b0, 32'hDE22BE44});
        vecs.push_back('{3'd4, 2'd2, 32'h12,  4'hF, 32'h0,        4'h9, 3'd1, 1'b1, 32'h0});
        vecs.push_back('{3'd0, 2'd1, 32'h22,  4'hC, 32'h55660000, 4'hA, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 2'd2, 32'h20,  4'hF, 32'h0,        4'hB, 3'd1, 1'b0, 32'h55660000});
        vecs.push_back('{3'd0, 2'd0, 32'h21,  4'h1, 32'h00007700, 4'hC, 3'd0, 1'b1, 32'h0});
        vecs.push_back('{3'd1, 2'd2, 32'h20,  4'h0, 32'h12345678, 4'hD, 3'd0, 1'b1, 32'h0});
        vecs.push_back('{3'd4, 2'd3, 32'h0,   4'hF, 32'h0,        4'hE, 3'd1, 1'b1, 32'h0});
        vecs.push_back('{3'd0, 2'd0, 32'h21,  4'h2, 32'h00007700, 4'hF, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 2'd2, 32'h20,  4'hF, 32'h0,        4'h0, 3'd1, 1'b0, 32'h55667700});
        vecs.push_back('{3'd0, 2'd2, 32'h3FC, 4'hF, 32'hCAFEF00D, 4'h1, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 2'd2, 32'h3FC, 4'hF, 32'h0,        4'h2, 3'd1, 1'b0, 32'hCAFEF00D});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
        chk("rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
        chk("rst_d_data", bus.d_data, 32'd0);
        chk("rst_raddr", {24'd0, ram_raddr}, 32'd0);
        rst = 1'b0; clear_mem = 1'b0;
        @(negedge clk);
        chk("idle_a_ready", {31'd0, bus.a_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) txn(vecs[i], 0, $sformatf("vec%0d", i));

        // Backpressure: d_ready low for 5 cycles on a read.
        rv = '{3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 4'h7, 3'd1, 1'b0, 32'hDE22BE44};
        txn(rv, 5, "bp_get");

        // Reset while waiting for read data: the response must never appear.
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_opcode = 3'd4; bus.a_size = 2'd2;
        bus.a_address = 32'h10; bus.a_mask = 4'hF; bus.a_source = 4'h3;
        @(posedge clk);
        #1 bus.a_valid = 1'b0;
        @(negedge clk);
        chk("rdwait_d_valid", {31'd0, bus.d_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_d_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("midrst_a_ready", {31'd0, bus.a_ready}, 32'd0);
        rst = 1'b0;
        begin
            bit stale;
            bit ready_ok;
            stale = 1'b0; ready_ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.d_valid) stale = 1'b1;
                if (!bus.a_ready) ready_ok = 1'b0;
            end
            chk("postrst_no_stale", {31'd0, stale}, 32'd0);
            chk("postrst_a_ready", {31'd0, ready_ok}, 32'd1);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            int pick;
            pick = $urandom_range(0, 9);
            rv.op   = (pick < 4) ? 3'd4 : (pick < 7) ? 3'd0 : (pick < 9) ? 3'd1 : 3'($urandom_range(0, 7));
            rv.sz   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            rv.addr = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) rv.addr = rv.addr + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rv.addr = 32'h400 + 32'($urandom_range(0, 4095));
            if (rv.op == 3'd0) begin
                if (rv.sz == 2'd0)      rv.mask = 4'b0001 << rv.addr[1:0];
                else if (rv.sz == 2'd1) rv.mask = 4'b0011 << rv.addr[1:0];
                else                    rv.mask = 4'hF;
                if ($urandom_range(0, 7) == 0) rv.mask = 4'($urandom);
            end else begin
                rv.mask = 4'($urandom);
            end
            rv.data  = $urandom;
            rv.src   = 4'($urandom);
            rv.e_err = ref_error(rv.op, rv.sz, rv.addr, rv.mask);
            rv.e_op  = (rv.op == 3'd4) ? 3'd1 : 3'd0;
            rv.e_data = (!rv.e_err && rv.op == 3'd4) ? ref_mem[rv.addr / 4] : 32'd0;
            txn(rv, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
